imm_extend_unit: RTL and testbench
==================================

IMM_EXTEND_UNIT -- requirements
Module: imm_extend_unit

Interface
REQ-001 The block SHALL have parameter OUT_W, default 16, meaning output result width.
REQ-002 The block SHALL have parameter IN_W, default 12, meaning input immediate field width; legal range W_MID < IN_W <= OUT_W.
REQ-003 The block SHALL have parameter W_SHORT, default 4, meaning short field width; legal range 1 <= W_SHORT < W_MID.
REQ-004 The block SHALL have parameter W_MID, default 8, meaning mid field width; legal range W_SHORT < W_MID < IN_W.
REQ-005 The block SHALL have port clk, input, 1 bit, meaning the single clock, rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit, meaning reset, synchronous and active-low.
REQ-007 The block SHALL have port in_valid, input, 1 bit, meaning the request is present.
REQ-008 The block SHALL have port in_ready, output, 1 bit, meaning the block can accept a request.
REQ-009 The block SHALL have port number, input, IN_W bits, meaning the raw immediate.
REQ-010 The block SHALL have port field_sel, input, 2 bits, with encoding 00=W_SHORT, 01=W_MID, 10=IN_W, 11=reserved.
REQ-011 The block SHALL have port mode, input, 1 bit, with encoding 0=zero pad, 1=sign extend.
REQ-012 The block SHALL have port out_valid, output, 1 bit, meaning the result is present.
REQ-013 The block SHALL have port out_ready, input, 1 bit, meaning the consumer accepts the result.
REQ-014 The block SHALL have port result, output, OUT_W bits, meaning the extended immediate.
REQ-015 The block SHALL have port out_err, output, 1 bit, meaning the result came from a reserved field_sel.

Function
REQ-016 A request SHALL be accepted on the rising clk edge where in_valid && in_ready.
REQ-017 The selected width SHALL be SW = W_SHORT, W_MID or IN_W per field_sel; bits number[IN_W-1:SW] SHALL be ignored.
REQ-018 When mode=0, result SHALL be the zero-extended number[SW-1:0]; when mode=1, number[SW-1] SHALL be replicated into result[OUT_W-1:SW].
REQ-019 When field_sel=11, the stored entry SHALL be result=0 with out_err=1; otherwise out_err SHALL be 0.
REQ-020 Computation SHALL occur at acceptance; with the buffer empty, out_valid SHALL assert on the cycle after acceptance (1-cycle latency).
REQ-021 Results SHALL be held in a 2-entry FIFO with occupancy states EMPTY, ONE and TWO; result, out_err and out_valid SHALL reflect the head entry.
REQ-022 Transitions SHALL be: EMPTY--push-->ONE; ONE--push only-->TWO; ONE--pop only-->EMPTY; ONE--push and pop-->ONE; TWO--pop-->ONE; no event SHALL leave the state unchanged.
REQ-023 A pop SHALL occur when out_valid && out_ready.
REQ-024 in_ready SHALL be a registered output equal to (state != TWO); in TWO, in_valid SHALL be ignored and no data SHALL be lost or overwritten.
REQ-025 While out_valid && !out_ready, result and out_err SHALL remain stable.
REQ-026 Output order SHALL equal acceptance order.
REQ-027 When out_valid=0, result and out_err SHALL be 0.

Reset
REQ-028 While rst_n=0 at a clk edge, state SHALL become EMPTY and out_valid, result and out_err SHALL become 0.
REQ-029 in_ready SHALL be 1 on the first cycle after rst_n deasserts.
REQ-030 Reset mid-operation SHALL discard all buffered entries; a request presented in the reset cycle SHALL NOT be accepted.

Configuration
REQ-031 With macro IMMEXT_SHIFT_EN defined, the block SHALL add input shamt (2 bits), captured with each request, and result SHALL be the extended value shifted left by shamt with the vacated LSBs zero and bits above OUT_W-1 discarded.
REQ-032 With IMMEXT_SHIFT_EN defined and field_sel=11, the reserved-select rule (result=0, out_err=1) SHALL take precedence over the shift.
REQ-033 Without IMMEXT_SHIFT_EN, the shamt port SHALL be absent and the shift logic SHALL NOT be present.

Verification (default parameters)
REQ-034 The bench SHALL apply number=12'h0F8, field_sel=01, mode=1 and require result=16'hFFF8 one cycle later; with mode=0, result=16'h00F8.
REQ-035 The bench SHALL apply number=12'hABC, field_sel=00, with mode=1 requiring 16'hFFFC, with mode=0 requiring 16'h000C; and number=12'h800, field_sel=10, mode=1 requiring 16'hF800.
REQ-036 The bench SHALL apply field_sel=11 with number=12'hFFF and require result=16'h0000 with out_err=1.
REQ-037 The bench SHALL hold out_ready=0 and offer requests A, B and C, requiring A and B accepted, in_ready=0 from the cycle after B is accepted, C held off, then out_ready=1 producing A, B, C in order.
REQ-038 The bench SHALL assert rst_n=0 with the state at TWO and require out_valid=0, in_ready=1 after release, and no stale data on the next output.
REQ-039 With IMMEXT_SHIFT_EN defined, the bench SHALL apply number=12'h081, field_sel=01, mode=1, shamt=2 and require result=16'hFE04.

Source files
------------

// File: rtl/imm_extend_unit.sv
// rtl/imm_extend_unit.sv - immediate zero/sign extender with a 2-entry result FIFO (optional shift: IMMEXT_SHIFT_EN)
module imm_extend_unit #(
    parameter int OUT_W   = 16,
    parameter int IN_W    = 12,
    parameter int W_SHORT = 4,
    parameter int W_MID   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  number,
    input  logic [1:0]       field_sel,
    input  logic             mode,
`ifdef IMMEXT_SHIFT_EN
    input  logic [1:0]       shamt,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] result,
    output logic             out_err
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [OUT_W-1:0] ext_val;
    logic [OUT_W-1:0] new_data;
    logic             new_err;
    logic [OUT_W-1:0] head_data, tail_data;
    logic             head_err, tail_err;
    logic             push, pop;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    // The signed cast replicates the top bit of the selected field up to OUT_W.
    always_comb begin
        ext_val = '0;
        unique case (field_sel)
            2'b00: ext_val = mode ? OUT_W'($signed(number[W_SHORT-1:0]))
                                  : OUT_W'(number[W_SHORT-1:0]);
            2'b01: ext_val = mode ? OUT_W'($signed(number[W_MID-1:0]))
                                  : OUT_W'(number[W_MID-1:0]);
            2'b10: ext_val = mode ? OUT_W'($signed(number[IN_W-1:0]))
                                  : OUT_W'(number[IN_W-1:0]);
            default: ext_val = '0;
        endcase
    end

    always_comb begin
        new_err = (field_sel == 2'b11);
`ifdef IMMEXT_SHIFT_EN
        new_data = new_err ? '0 : (ext_val << shamt);
`else
        new_data = new_err ? '0 : ext_val;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= EMPTY;
            in_ready <= 1'b1;
        end else begin
            state_q  <= state_d;
            in_ready <= (state_d != TWO);
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EMPTY:   if (push) state_d = ONE;
            ONE: begin
                if (push && !pop)      state_d = TWO;
                else if (pop && !push) state_d = EMPTY;
            end
            TWO:     if (pop) state_d = ONE;
            default: state_d = EMPTY;
        endcase
    end

    // Head is what the consumer sees; tail is only occupied in TWO.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_data <= '0;
            head_err  <= 1'b0;
            tail_data <= '0;
            tail_err  <= 1'b0;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (push) begin
                        head_data <= new_data;
                        head_err  <= new_err;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        head_data <= new_data;
                        head_err  <= new_err;
                    end else if (push) begin
                        tail_data <= new_data;
                        tail_err  <= new_err;
                    end
                end
                TWO: begin
                    if (pop) begin
                        head_data <= tail_data;
                        head_err  <= tail_err;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        out_valid = (state_q != EMPTY);
        result    = out_valid ? head_data : '0;
        out_err   = out_valid ? head_err : 1'b0;
    end

endmodule

// File: tb/tb_imm_extend_unit.sv
// tb/tb_imm_extend_unit.sv - self-checking bench for imm_extend_unit (shift cases under IMMEXT_SHIFT_EN)
module tb_imm_extend_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [11:0] number = '0;
    logic [1:0]  field_sel = '0;
    logic        mode = 1'b0;
    logic [1:0]  shamt = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] result;
    logic        out_err;

    int checks = 0;
    int errors = 0;

    imm_extend_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .number    (number),
        .field_sel (field_sel),
        .mode      (mode),
`ifdef IMMEXT_SHIFT_EN
        .shamt     (shamt),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    // Reference: {err, result} from the field width rules using plain integer arithmetic.
    function automatic logic [16:0] ref_ext(input logic [11:0] n, input logic [1:0] fs,
                                            input logic m, input int sh);
        longint sw, v;
        if (fs == 2'b11) return {1'b1, 16'h0000};
        sw = (fs == 2'b00) ? 4 : (fs == 2'b01) ? 8 : 12;
        v  = longint'(n) % (longint'(1) << sw);
        if (m && v >= (longint'(1) << (sw - 1)))
            v = v + 65536 - (longint'(1) << sw);
        v = (v << sh) % 65536;
        return {1'b0, v[15:0]};
    endfunction

    localparam logic [11:0] D_NUM [6] = '{12'h0F8, 12'h0F8, 12'hABC, 12'hABC, 12'h800, 12'hFFF};
    localparam logic [1:0]  D_FS  [6] = '{2'b01, 2'b01, 2'b00, 2'b00, 2'b10, 2'b11};
    localparam logic        D_MD  [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    localparam logic [15:0] D_RES [6] = '{16'hFFF8, 16'h00F8, 16'hFFFC, 16'h000C, 16'hF800, 16'h0000};
    localparam logic        D_ERR [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    task automatic present(input logic [11:0] n, input logic [1:0] fs, input logic m);
        in_valid  = 1'b1;
        number    = n;
        field_sel = fs;
        mode      = m;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || result !== 16'h0 || out_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b result=%h err=%b, required 0/0000/0", out_valid, result, out_err);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b, required 1", in_ready);
        end
    endtask

    task automatic test_directed;
        out_ready = 1'b1;
        shamt = 2'd0;
        for (int i = 0; i < 6; i++) begin
            present(D_NUM[i], D_FS[i], D_MD[i]);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            checks++;
            if (out_valid !== 1'b1 || result !== D_RES[i] || out_err !== D_ERR[i]) begin
                errors++;
                $display("FAIL directed_%0d: valid=%b result=%h err=%b, required 1/%h/%b",
                         i, out_valid, result, out_err, D_RES[i], D_ERR[i]);
            end
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b0 || result !== 16'h0) begin
                errors++;
                $display("FAIL directed_drain_%0d: valid=%b result=%h, required 0/0000", i, out_valid, result);
            end
        end
    endtask

`ifdef IMMEXT_SHIFT_EN
    task automatic test_shift;
        out_ready = 1'b1;
        shamt = 2'd2;
        present(12'h081, 2'b01, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || result !== 16'hFE04 || out_err !== 1'b0) begin
            errors++;
            $display("FAIL shift: valid=%b result=%h err=%b, required 1/fe04/0", out_valid, result, out_err);
        end
        present(12'hFFF, 2'b11, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if (result !== 16'h0 || out_err !== 1'b1) begin
            errors++;
            $display("FAIL shift_reserved: result=%h err=%b, required 0000/1", result, out_err);
        end
        @(posedge clk);
        #1;
        shamt = 2'd0;
    endtask
`endif

    task automatic test_backpressure;
        out_ready = 1'b0;
        present(12'h111, 2'b10, 1'b0);
        @(posedge clk);
        #1;
        present(12'h222, 2'b10, 1'b0);
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_full_ready: got %b, required 0", in_ready);
        end
        present(12'h333, 2'b10, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b0 || result !== 16'h0111) begin
            errors++;
            $display("FAIL bp_hold: ready=%b result=%h, required 0/0111", in_ready, result);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || result !== 16'h0222) begin
            errors++;
            $display("FAIL bp_order_b: valid=%b result=%h, required 1/0222", out_valid, result);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || result !== 16'h0333) begin
            errors++;
            $display("FAIL bp_order_c: valid=%b result=%h, required 1/0333", out_valid, result);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_empty: valid=%b ready=%b, required 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid;
        out_ready = 1'b0;
        present(12'h0AA, 2'b10, 1'b0);
        @(posedge clk);
        #1;
        present(12'h0BB, 2'b10, 1'b0);
        @(posedge clk);
        #1;
        present(12'h0DD, 2'b10, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 16'h0) begin
            errors++;
            $display("FAIL rst_mid: valid=%b ready=%b result=%h, required 0/1/0000", out_valid, in_ready, result);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_no_accept: valid=%b, required 0", out_valid);
        end
        out_ready = 1'b1;
        present(12'h0EE, 2'b10, 1'b0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || result !== 16'h00EE) begin
            errors++;
            $display("FAIL rst_mid_fresh: valid=%b result=%h, required 1/00ee", out_valid, result);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_random;
        logic [16:0] q[$];
        logic [16:0] exp;
        logic        push, pop;
        int          sh;
        for (int i = 0; i < 400; i++) begin
            exp = (q.size() > 0) ? q[0] : 17'h0;
            checks++;
            if (out_valid !== (q.size() > 0) || in_ready !== (q.size() < 2) ||
                result !== exp[15:0] || out_err !== exp[16]) begin
                errors++;
                $display("FAIL random_%0d: valid=%b ready=%b result=%h err=%b, required %b/%b/%h/%b",
                         i, out_valid, in_ready, result, out_err,
                         q.size() > 0, q.size() < 2, exp[15:0], exp[16]);
            end
            in_valid  = $urandom_range(0, 3) != 0;
            out_ready = $urandom_range(0, 2) != 0;
            number    = 12'($urandom);
            field_sel = 2'($urandom);
            mode      = 1'($urandom);
            sh = 0;
`ifdef IMMEXT_SHIFT_EN
            shamt = 2'($urandom);
            sh = int'(shamt);
`endif
            push = in_valid && (q.size() < 2);
            pop  = out_ready && (q.size() > 0);
            exp  = ref_ext(number, field_sel, mode, sh);
            @(posedge clk);
            #1;
            if (pop) void'(q.pop_front());
            if (push) q.push_back(exp);
        end
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_directed();
`ifdef IMMEXT_SHIFT_EN
        test_shift();
`endif
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
